obi_rr_arbiter: RTL

- Round-robin OBI arbiter that shares one OBI master port between NUM_REQ requesters. It is used in the core testbench wrapper to merge instruction, data and debug-module traffic onto a single memory model.
- Unlike a single-outstanding priority arbiter, it pipelines up to MAX_OUTSTANDING transactions.
- Responses are returned in order, using an owner-ID FIFO.

---
 rtl/obi_rr_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter with in-order response routing via an owner-ID FIFO.
// Define OBI_RR_ARBITER_ERR_CHECK_EN to build the sticky protocol-error flag.
module obi_rr_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     s_req_i,
  input  logic [NUM_REQ*32-1:0]  s_addr_i,
  input  logic [NUM_REQ-1:0]     s_we_i,
  input  logic [NUM_REQ*4-1:0]   s_be_i,
  input  logic [NUM_REQ*32-1:0]  s_wdata_i,
  output logic [NUM_REQ-1:0]     s_gnt_o,
  output logic [NUM_REQ-1:0]     s_rvalid_o,
  output logic [31:0]            s_rdata_o,
  output logic                   m_req_o,
  output logic [31:0]            m_addr_o,
  output logic                   m_we_o,
  output logic [3:0]             m_be_o,
  output logic [31:0]            m_wdata_o,
  input  logic                   m_gnt_i,
  input  logic                   m_rvalid_i,
  input  logic [31:0]            m_rdata_i,
  output logic                   err_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      sel_q;
  logic               lock_q;
  logic [PW-1:0]      fifo_q [MAX_OUTSTANDING];
  logic [FW-1:0]      wr_ptr_q;
  logic [FW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;

  logic [PW-1:0]      sel_rr;
  logic [PW-1:0]      sel;
  logic [PW-1:0]      head;
  logic [PW-1:0]      rr_nxt;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0] req_rot;
  logic               req_sel;
  logic               full;
  logic               empty;
  logic               hs;
  logic               pop;

  // Rotate requests so bit 0 is the requester at rr_ptr_q.
  assign req_dbl = {s_req_i, s_req_i} >> rr_ptr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    logic found;
    int   tmp;
    found  = 1'b0;
    tmp    = 0;
    sel_rr = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        tmp   = int'(rr_ptr_q) + i;
        if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
        sel_rr = PW'(tmp);
      end
    end
  end

  assign sel   = lock_q ? sel_q : sel_rr;
  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  always_comb begin
    req_sel   = 1'b0;
    m_addr_o  = '0;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_wdata_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == PW'(k)) begin
        req_sel   = s_req_i[k];
        m_addr_o  = s_addr_i[32*k +: 32];
        m_we_o    = s_we_i[k];
        m_be_o    = s_be_i[4*k +: 4];
        m_wdata_o = s_wdata_i[32*k +: 32];
      end
    end
  end

  assign m_req_o   = req_sel & ~full;
  assign hs        = m_req_o & m_gnt_i;
  assign pop       = m_rvalid_i & ~empty;
  assign s_rdata_o = m_rdata_i;
  assign rr_nxt    = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);

  always_comb begin
    s_gnt_o    = '0;
    s_rvalid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s_gnt_o[k]    = hs & (sel == PW'(k));
      s_rvalid_o[k] = pop & (head == PW'(k));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lock_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      // Hold the stalled winner so its address phase stays stable.
      if (hs) begin
        rr_ptr_q <= rr_nxt;
        lock_q   <= 1'b0;
      end else if (m_req_o) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end else begin
        lock_q <= 1'b0;
      end
      if (hs) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q <= (wr_ptr_q == FW'(MAX_OUTSTANDING - 1)) ?
                    '0 : wr_ptr_q + FW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == FW'(MAX_OUTSTANDING - 1)) ?
                    '0 : rd_ptr_q + FW'(1);
      end
      if (hs && !pop)      count_q <= count_q + CW'(1);
      else if (!hs && pop) count_q <= count_q - CW'(1);
    end
  end

`ifdef OBI_RR_ARBITER_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((m_rvalid_i & empty) | (m_gnt_i & ~m_req_o)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
